// File: rtl/shift_in_deserializer_pkg.sv
// Shared definitions for the serial receive path.
// The default frame width is also used by the transmit-side shifter, so both
// ends of the link agree on frame size.
package shift_in_deserializer_pkg;

    localparam int DEFAULT_WIDTH = 4;

    // Receiver FSM encoding
    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SHIFT = 1'b1;

    // Decision for the double-buffered output stage in one cycle
    typedef struct packed {
        logic load;      // completed word goes into data_out
        logic consume;   // consumer takes the current word
        logic ovr_set;   // completed word is dropped
    } buf_ctrl_t;

    // A completed word loads when the buffer is empty or being drained in
    // the same cycle; otherwise it is dropped and overrun is flagged.
    function automatic buf_ctrl_t buf_decide(input logic complete,
                                             input logic valid,
                                             input logic ready);
        buf_ctrl_t c;
        c.consume = valid & ready;
        c.load    = complete & (~valid | ready);
        c.ovr_set = complete & valid & ~ready;
        return c;
    endfunction

endpackage

// File: rtl/shift_in_deserializer_sipo.sv
// Serial-in parallel-out shift register. New bits enter at the MSB and move
// right, so after WIDTH shifts bit 0 holds the first bit received.
module sipo_shift_reg
    import shift_in_deserializer_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             areset,
    input  logic             shift_en,
    input  logic             clr,
    input  logic             sin,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] sr_q;
    logic [WIDTH-1:0] sr_d;

    // Next value: clear has priority over a shift
    always_comb begin
        sr_d = sr_q;
        if (clr) begin
            sr_d = '0;
        end else if (shift_en) begin
            sr_d = {sin, sr_q[WIDTH-1:1]};
        end
    end

    // Register with asynchronous reset
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

    assign q = sr_q;

endmodule

// File: rtl/shift_in_deserializer.sv
// Serial-to-parallel receiver. Collects WIDTH bits LSB first, one per ena
// strobe, framed by a start marker on bit 0, and hands each completed word
// to the consumer through a single-entry valid/ready output buffer.
module shift_in_deserializer
    import shift_in_deserializer_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             areset,
    input  logic             ena,
    input  logic             sin,
    input  logic             start,
    input  logic             ready,
    input  logic             clr_ovr,
    output logic [WIDTH-1:0] data_out,
    output logic             valid,
    output logic             busy,
    output logic             overrun,
    output logic             resync
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    logic [0:0]       state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;
    logic             overrun_q, overrun_d;
    logic             resync_q, resync_d;

    logic             capture;
    logic             complete;
    logic [WIDTH-1:0] sr;
    logic [WIDTH-1:0] word;
    buf_ctrl_t        bctl;

    sipo_shift_reg #(
        .WIDTH (WIDTH)
    ) u_sr (
        .clk      (clk),
        .areset   (areset),
        .shift_en (capture),
        .clr      (complete),
        .sin      (sin),
        .q        (sr)
    );

    // The word as it will look including the bit being sampled this cycle
    assign word = {sin, sr[WIDTH-1:1]};

    // Frame FSM and bit counter; a start inside a frame restarts it at bit 0
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        capture  = 1'b0;
        complete = 1'b0;
        resync_d = 1'b0;
        if (state_q == ST_IDLE) begin
            if (ena && start) begin
                capture = 1'b1;
                count_d = CNT_ONE;
                state_d = ST_SHIFT;
            end
        end else begin
            if (ena) begin
                capture = 1'b1;
                if (start) begin
                    count_d  = CNT_ONE;
                    resync_d = 1'b1;
                end else if (count_q == CNT_LAST) begin
                    complete = 1'b1;
                    count_d  = '0;
                    state_d  = ST_IDLE;
                end else begin
                    count_d = count_q + CNT_ONE;
                end
            end
        end
    end

    // Output buffer and sticky overrun; a new overrun beats clr_ovr
    always_comb begin
        bctl      = buf_decide(complete, valid_q, ready);
        data_d    = data_q;
        valid_d   = valid_q;
        if (bctl.load) begin
            data_d  = word;
            valid_d = 1'b1;
        end else if (bctl.consume) begin
            valid_d = 1'b0;
        end
        overrun_d = bctl.ovr_set | (overrun_q & ~clr_ovr);
    end

    // State registers, all cleared by the asynchronous reset
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            state_q   <= ST_IDLE;
            count_q   <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
            resync_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
            resync_q  <= resync_d;
        end
    end

    assign data_out = data_q;
    assign valid    = valid_q;
    assign busy     = (state_q == ST_SHIFT);
    assign overrun  = overrun_q;
    assign resync   = resync_q;

endmodule

// File: tb/tb_shift_in_deserializer.sv
// Self-checking bench for shift_in_deserializer (WIDTH=4). Expected words are
// queued when a frame is sent and popped when the DUT presents them.
module tb_shift_in_deserializer;

    localparam int WIDTH = 4;

    logic             clk;
    logic             areset;
    logic             ena;
    logic             sin;
    logic             start;
    logic             ready;
    logic             clr_ovr;
    logic [WIDTH-1:0] data_out;
    logic             valid;
    logic             busy;
    logic             overrun;
    logic             resync;

    int checks;
    int failures;
    logic [WIDTH-1:0] exp_q[$];

    shift_in_deserializer #(
        .WIDTH (WIDTH)
    ) dut (
        .clk      (clk),
        .areset   (areset),
        .ena      (ena),
        .sin      (sin),
        .start    (start),
        .ready    (ready),
        .clr_ovr  (clr_ovr),
        .data_out (data_out),
        .valid    (valid),
        .busy     (busy),
        .overrun  (overrun),
        .resync   (resync)
    );

    // Free-running clock, posedges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog so the run always ends
    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h required=0x%0h", tag, actual, expected);
        end
    endtask

    // Drive one cycle of inputs, then sample just after the posedge
    task automatic applyStimulus(input logic e, input logic s, input logic st,
                                 input logic r, input logic c);
        ena     = e;
        sin     = s;
        start   = st;
        ready   = r;
        clr_ovr = c;
        @(posedge clk);
        #1;
    endtask

    // Send a full frame LSB first; ready is applied only on the last bit
    task automatic sendFrame(input logic [WIDTH-1:0] w, input logic last_ready);
        for (int i = 0; i < WIDTH; i++) begin
            applyStimulus(1'b1, w[i], (i == 0), (i == WIDTH - 1) ? last_ready : 1'b0, 1'b0);
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic checkWord(input string tag);
        logic [WIDTH-1:0] e;
        if (exp_q.size() == 0) begin
            checkOutput({tag, "_sb_empty"}, 32'(exp_q.size()), 32'd1);
        end else begin
            e = exp_q.pop_front();
            checkOutput(tag, 32'(data_out), 32'(e));
        end
    endtask

    task automatic consume();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("consume_valid", 32'(valid), 32'd0);
    endtask

    logic [WIDTH-1:0] w;
    int gap;

    initial begin
        checks   = 0;
        failures = 0;
        areset   = 1'b1;
        ena = 1'b0; sin = 1'b0; start = 1'b0; ready = 1'b0; clr_ovr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_data", 32'(data_out), 32'd0);
        checkOutput("rst_valid", 32'(valid), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_overrun", 32'(overrun), 32'd0);
        checkOutput("rst_resync", 32'(resync), 32'd0);
        areset = 1'b0;

        // ena without start in IDLE does nothing
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("idle_ena_busy", 32'(busy), 32'd0);

        // Basic frame 4'hD
        w = 4'hD;
        exp_q.push_back(w);
        for (int i = 0; i < WIDTH; i++) begin
            applyStimulus(1'b1, w[i], (i == 0), 1'b0, 1'b0);
            if (i < WIDTH - 1) begin
                checkOutput("basic_busy", 32'(busy), 32'd1);
                checkOutput("basic_novalid", 32'(valid), 32'd0);
            end
        end
        checkOutput("basic_valid", 32'(valid), 32'd1);
        checkOutput("basic_busy_done", 32'(busy), 32'd0);
        checkWord("basic_data");
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("basic_hold", 32'(valid), 32'd1);
        consume();

        // Sparse ena, gaps of 0..3 idle cycles between bits
        exp_q.push_back(w);
        for (int i = 0; i < WIDTH; i++) begin
            applyStimulus(1'b1, w[i], (i == 0), 1'b0, 1'b0);
            if (i < WIDTH - 1) begin
                gap = $urandom_range(3, 0);
                for (int g = 0; g < gap; g++) begin
                    applyStimulus(1'b0, ~w[i], 1'b1, 1'b0, 1'b0);
                    checkOutput("sparse_busy", 32'(busy), 32'd1);
                    checkOutput("sparse_novalid", 32'(valid), 32'd0);
                end
            end
        end
        checkOutput("sparse_valid", 32'(valid), 32'd1);
        checkWord("sparse_data");
        consume();

        // Overrun: 4'hD held, 4'h6 dropped
        exp_q.push_back(4'hD);
        sendFrame(4'hD, 1'b0);
        sendFrame(4'h6, 1'b0);
        checkOutput("ovr_valid", 32'(valid), 32'd1);
        checkOutput("ovr_flag", 32'(overrun), 32'd1);
        checkWord("ovr_data");
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("ovr_clear", 32'(overrun), 32'd0);
        checkOutput("ovr_clear_valid", 32'(valid), 32'd1);

        // Simultaneous consume and complete: 4'h6 replaces 4'hD
        exp_q.push_back(4'h6);
        sendFrame(4'h6, 1'b1);
        checkOutput("sim_valid", 32'(valid), 32'd1);
        checkOutput("sim_overrun", 32'(overrun), 32'd0);
        checkWord("sim_data");
        consume();

        // Resync: two bits, then a fresh frame 4'hC
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("resync_before", 32'(resync), 32'd0);
        w = 4'hC;
        exp_q.push_back(w);
        applyStimulus(1'b1, w[0], 1'b1, 1'b0, 1'b0);
        checkOutput("resync_pulse", 32'(resync), 32'd1);
        checkOutput("resync_busy", 32'(busy), 32'd1);
        applyStimulus(1'b1, w[1], 1'b0, 1'b0, 1'b0);
        checkOutput("resync_end", 32'(resync), 32'd0);
        applyStimulus(1'b1, w[2], 1'b0, 1'b0, 1'b0);
        checkOutput("resync_novalid", 32'(valid), 32'd0);
        applyStimulus(1'b1, w[3], 1'b0, 1'b0, 1'b0);
        checkOutput("resync_valid", 32'(valid), 32'd1);
        checkWord("resync_data");
        consume();

        // Async reset mid-frame with a held word and overrun pending
        exp_q.push_back(4'hD);
        sendFrame(4'hD, 1'b0);
        sendFrame(4'h6, 1'b0);
        checkWord("pre_rst_data");
        checkOutput("pre_rst_ovr", 32'(overrun), 32'd1);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        ena = 1'b0; start = 1'b0;
        #3;
        areset = 1'b1;
        #1;
        checkOutput("arst_data", 32'(data_out), 32'd0);
        checkOutput("arst_valid", 32'(valid), 32'd0);
        checkOutput("arst_busy", 32'(busy), 32'd0);
        checkOutput("arst_overrun", 32'(overrun), 32'd0);
        checkOutput("arst_resync", 32'(resync), 32'd0);
        @(posedge clk);
        #1;
        areset = 1'b0;

        // Clean frame 4'hA after reset
        exp_q.push_back(4'hA);
        sendFrame(4'hA, 1'b0);
        checkOutput("post_rst_valid", 32'(valid), 32'd1);
        checkWord("post_rst_data");
        consume();
        checkOutput("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
